uart_hd_sched: RTL

//  Half-duplex UART sequencer that shares one baud_gen instance between a TX and an RX path.

---
 rtl/uart_hd_sched_pkg.sv | 24 ++
 rtl/uart_hd_sched_sync_ff.sv | 33 +++
 rtl/uart_hd_sched.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/uart_hd_sched_pkg.sv
// ============================================================================
// uart_hd_sched_pkg : shared state encoding and line constants for the
//                     half-duplex UART sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_hd_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_START = 3'd1,
    S_TX_DATA  = 3'd2,
    S_TX_STOP  = 3'd3,
    S_RX_START = 3'd4,
    S_RX_DATA  = 3'd5,
    S_RX_STOP  = 3'd6
  } state_t;

  localparam logic UART_IDLE_LVL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_hd_sched_sync_ff.sv
// ============================================================================
// sync_ff : multi-stage synchronizer with a configurable reset level
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_ff
  import uart_hd_sched_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = UART_IDLE_LVL
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/uart_hd_sched.sv
// ============================================================================
// uart_hd_sched : half-duplex UART sequencer sharing one baud generator
//                 between TX and RX, with RX given priority
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_hd_sched
  import uart_hd_sched_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  input  logic                 rxd,
  output logic                 txd,
  output logic                 busy,
  output logic                 init_tx,
  output logic                 init_rx,
  output logic                 en_tx,
  output logic                 en_rx,
  input  logic                 baud_pulse
);

  localparam int               CNT_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, rx_err_q, txd_q;
  logic                 rxd_s, rxd_prev_q, start_edge, rx_done;

  sync_ff #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (UART_IDLE_LVL)
  ) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rxd),
    .q_o (rxd_s)
  );

  assign start_edge = rxd_prev_q & ~rxd_s;

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    init_tx  = 1'b0;
    init_rx  = 1'b0;
    tx_ready = 1'b0;
    rx_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A line start edge cannot wait, so it pre-empts a pending TX request.
        if (!rst) begin
          tx_ready = ~start_edge;
          if (start_edge) begin
            state_d = S_RX_START;
            init_rx = 1'b1;
          end else if (tx_valid) begin
            state_d = S_TX_START;
            shift_d = tx_data;
            init_tx = 1'b1;
          end
        end
      end
      S_TX_START: begin
        if (baud_pulse) begin
          state_d = S_TX_DATA;
          cnt_d   = '0;
        end
      end
      S_TX_DATA: begin
        if (baud_pulse) begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = S_TX_STOP;
        end
      end
      S_TX_STOP: begin
        if (baud_pulse) state_d = S_IDLE;
      end
      S_RX_START: begin
        if (baud_pulse) begin
          if (rxd_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RX_DATA;
            cnt_d   = '0;
          end
        end
      end
      S_RX_DATA: begin
        if (baud_pulse) begin
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) state_d = S_RX_STOP;
        end
      end
      S_RX_STOP: begin
        if (baud_pulse) begin
          rx_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      cnt_q      <= '0;
      txd_q      <= UART_IDLE_LVL;
      rxd_prev_q <= UART_IDLE_LVL;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      rxd_prev_q <= rxd_s;
      rx_valid_q <= rx_done;
      if (rx_done) begin
        rx_data_q <= shift_q;
        rx_err_q  <= ~rxd_s;
      end
      case (state_q)
        S_TX_START: txd_q <= 1'b0;
        S_TX_DATA:  txd_q <= shift_q[0];
        default:    txd_q <= UART_IDLE_LVL;
      endcase
    end
  end

  assign txd          = txd_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_err_q;
  assign busy         = (state_q != S_IDLE);
  assign en_tx        = (state_q == S_TX_START) || (state_q == S_TX_DATA) || (state_q == S_TX_STOP);
  assign en_rx        = (state_q == S_RX_START) || (state_q == S_RX_DATA) || (state_q == S_RX_STOP);

endmodule

`default_nettype wire
